// File: rtl/multi_cycle_control_if.sv
// multi_cycle_control_if: control bundle between the multi-cycle MIPS controller and its datapath.
interface multi_cycle_control_if #(parameter int CNT_WIDTH = 32);
   logic [5:0]           opcode;
   logic                 mem_ready;
   logic                 pc_write;
   logic                 pc_write_cond;
   logic                 i_or_d;
   logic                 mem_read;
   logic                 mem_write;
   logic                 ir_write;
   logic                 mem_to_reg;
   logic                 reg_dst;
   logic                 reg_write;
   logic                 alu_src_a;
   logic [1:0]           alu_src_b;
   logic [1:0]           pc_source;
   logic [3:0]           alu_op;
   logic                 sign_extend;
   logic                 exception;
   logic [3:0]           state;
   logic [CNT_WIDTH-1:0] retired;
   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, sign_extend,
             exception, state, retired
   );
   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, sign_extend,
             exception, state, retired
   );
endinterface

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: Moore control FSM sequencing the shared-resource multi-cycle MIPS datapath.
module multi_cycle_control #(
   parameter bit USE_MEMREADY = 1'b1,
   parameter int CNT_WIDTH    = 32
) (
   input logic                  clk,
   input logic                  reset,
   multi_cycle_control_if.master bus
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
      EXECR = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, EXECI = 4'd10, IWB = 4'd11
   } state_t;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                          OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011,
                          OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_XORI = 6'b001110,
                          OP_LUI = 6'b001111;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_FUNCT = 4'd2, ALU_OR = 4'd3,
                          ALU_AND = 4'd4, ALU_XOR = 4'd5, ALU_LUI = 4'd6, ALU_SLT = 4'd7,
                          ALU_SLTU = 4'd8;
   state_t               state, nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 rdy, is_imm, legal, retire;
   logic [5:0]           op;
   assign op     = bus.opcode;
   assign rdy    = USE_MEMREADY ? bus.mem_ready : 1'b1;
   assign is_imm = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
   assign legal  = is_imm || (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J});
   assign retire = (state inside {MEMWB, RWB, BRANCH, JUMP, IWB}) || (state == MEMWR && rdy);
   assign bus.state   = state;
   assign bus.retired = cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= retire ? cnt + CNT_WIDTH'(1) : cnt;
      end
   end
   always_comb begin
      nxt               = FETCH;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.pc_source     = 2'b00;
      bus.alu_op        = ALU_ADD;
      bus.sign_extend   = 1'b0;
      bus.exception     = 1'b0;
      case (state)
         FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.ir_write  = rdy;
            bus.pc_write  = rdy;
            nxt           = rdy ? DECODE : FETCH;
         end
         DECODE: begin
            bus.alu_src_b   = 2'b11;
            bus.sign_extend = 1'b1;
            bus.exception   = !legal;
            nxt = op == OP_R ? EXECR : (op == OP_LW || op == OP_SW) ? MEMADR :
                  op == OP_BEQ ? BRANCH : op == OP_J ? JUMP : is_imm ? EXECI : FETCH;
         end
         MEMADR: begin
            bus.alu_src_a   = 1'b1;
            bus.alu_src_b   = 2'b10;
            bus.sign_extend = 1'b1;
            nxt             = op == OP_LW ? MEMRD : MEMWR;
         end
         MEMRD: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
            nxt          = rdy ? MEMWB : MEMRD;
         end
         MEMWB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
         end
         MEMWR: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
            nxt           = rdy ? FETCH : MEMWR;
         end
         EXECR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = ALU_FUNCT;
            nxt           = RWB;
         end
         RWB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
         end
         BRANCH: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = ALU_SUB;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 2'b01;
         end
         JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'b10;
         end
         EXECI: begin
            bus.alu_src_a   = 1'b1;
            bus.alu_src_b   = 2'b10;
            bus.alu_op      = op == OP_SLTI ? ALU_SLT : op == OP_SLTIU ? ALU_SLTU :
                              op == OP_ORI ? ALU_OR : op == OP_ANDI ? ALU_AND :
                              op == OP_XORI ? ALU_XOR : op == OP_LUI ? ALU_LUI : ALU_ADD;
            bus.sign_extend = !(op inside {OP_ORI, OP_ANDI, OP_XORI, OP_LUI});
            nxt             = IWB;
         end
         IWB: bus.reg_write = 1'b1;
         default: nxt = FETCH;
      endcase
      // reset aborts the instruction, so no enable may fire in the reset cycle
      if (reset) begin
         bus.pc_write      = 1'b0;
         bus.pc_write_cond = 1'b0;
         bus.mem_read      = 1'b0;
         bus.mem_write     = 1'b0;
         bus.ir_write      = 1'b0;
         bus.reg_write     = 1'b0;
         bus.exception     = 1'b0;
      end
   end
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: table-driven check of the multi-cycle MIPS control FSM plus counter wrap.
module tb_multi_cycle_control;
   typedef struct {
      bit          rst;
      logic [5:0]  op;
      bit          rdy;
      int          st;
      logic [19:0] ctl;
      logic [19:0] msk;
      int          ret;
   } vec_t;
   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                          J = 6'b000010, ORI = 6'b001101, ANDI = 6'b001100, XORI = 6'b001110,
                          LUI = 6'b001111, SLTI = 6'b001010, SLTIU = 6'b001011,
                          ADDIU = 6'b001001, BAD = 6'b111111;
   // field order: pw pwc iord mr mw irw m2r rd rw asa | asb | pcs | aluop | se ex
   localparam logic [19:0] C_ALL  = 20'hFFFFF,
                           C_EN   = 20'b1101110010_00_00_0000_01,
                           C_FR   = 20'b1001010000_01_00_0000_00,
                           C_FN   = 20'b0001000000_01_00_0000_00,
                           C_DEC  = 20'b0000000000_11_00_0000_10,
                           C_DECX = 20'b0000000000_11_00_0000_11,
                           C_MADR = 20'b0000000001_10_00_0000_10,
                           C_MRD  = 20'b0011000000_00_00_0000_00,
                           C_MWB  = 20'b0000001010_00_00_0000_00,
                           C_MWR  = 20'b0010100000_00_00_0000_00,
                           C_EXR  = 20'b0000000001_00_00_0010_00,
                           C_RWB  = 20'b0000000110_00_00_0000_00,
                           C_BR   = 20'b0100000001_00_01_0001_00,
                           C_JMP  = 20'b1000000000_00_10_0000_00,
                           C_IWB  = 20'b0000000010_00_00_0000_00,
                           C_IORI = 20'b0000000001_10_00_0011_00,
                           C_IAND = 20'b0000000001_10_00_0100_00,
                           C_IXOR = 20'b0000000001_10_00_0101_00,
                           C_ILUI = 20'b0000000001_10_00_0110_00,
                           C_ISLT = 20'b0000000001_10_00_0111_10,
                           C_ISLU = 20'b0000000001_10_00_1000_10,
                           C_IADU = 20'b0000000001_10_00_0000_10;
   logic clk = 1'b0, reset = 1'b1, reset2 = 1'b1;
   int   checks = 0, errors = 0;
   vec_t tv[$];
   multi_cycle_control_if #(.CNT_WIDTH(32)) b0 ();
   multi_cycle_control_if #(.CNT_WIDTH(4))  b1 ();
   multi_cycle_control #(.USE_MEMREADY(1'b1), .CNT_WIDTH(32)) u0 (.clk(clk), .reset(reset), .bus(b0));
   multi_cycle_control #(.USE_MEMREADY(1'b0), .CNT_WIDTH(4))  u1 (.clk(clk), .reset(reset2), .bus(b1));
   always #5 clk = ~clk;
   wire [19:0] ctl = {b0.pc_write, b0.pc_write_cond, b0.i_or_d, b0.mem_read, b0.mem_write,
                      b0.ir_write, b0.mem_to_reg, b0.reg_dst, b0.reg_write, b0.alu_src_a,
                      b0.alu_src_b, b0.pc_source, b0.alu_op, b0.sign_extend, b0.exception};
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic v(input bit r, input logic [5:0] o, input bit m, input int s,
                    input logic [19:0] c, input int rt, input logic [19:0] k = C_ALL);
      tv.push_back('{rst: r, op: o, rdy: m, st: s, ctl: c, msk: k, ret: rt});
   endtask
   initial begin
      // R, lw, sw, beq, j, ori back to back with memory always ready
      v(0, R, 1, 0, C_FR, 0);    v(0, R, 1, 1, C_DEC, 0);   v(0, R, 1, 6, C_EXR, 0);
      v(0, R, 1, 7, C_RWB, 0);
      v(0, LW, 1, 0, C_FR, 1);   v(0, LW, 1, 1, C_DEC, 1);  v(0, LW, 1, 2, C_MADR, 1);
      v(0, LW, 1, 3, C_MRD, 1);  v(0, LW, 1, 4, C_MWB, 1);
      v(0, SW, 1, 0, C_FR, 2);   v(0, SW, 1, 1, C_DEC, 2);  v(0, SW, 1, 2, C_MADR, 2);
      v(0, SW, 1, 5, C_MWR, 2);
      v(0, BEQ, 1, 0, C_FR, 3);  v(0, BEQ, 1, 1, C_DEC, 3); v(0, BEQ, 1, 8, C_BR, 3);
      v(0, J, 1, 0, C_FR, 4);    v(0, J, 1, 1, C_DEC, 4);   v(0, J, 1, 9, C_JMP, 4);
      v(0, ORI, 1, 0, C_FR, 5);  v(0, ORI, 1, 1, C_DEC, 5); v(0, ORI, 1, 10, C_IORI, 5);
      v(0, ORI, 1, 11, C_IWB, 5);
      // lw with two fetch stalls and three read stalls: 10 cycles
      v(0, LW, 0, 0, C_FN, 6);   v(0, LW, 0, 0, C_FN, 6);   v(0, LW, 1, 0, C_FR, 6);
      v(0, LW, 1, 1, C_DEC, 6);  v(0, LW, 1, 2, C_MADR, 6);
      v(0, LW, 0, 3, C_MRD, 6);  v(0, LW, 0, 3, C_MRD, 6);  v(0, LW, 0, 3, C_MRD, 6);
      v(0, LW, 1, 3, C_MRD, 6);  v(0, LW, 1, 4, C_MWB, 6);
      // immediate ALU op decoding
      v(0, ANDI, 1, 0, C_FR, 7);   v(0, ANDI, 1, 1, C_DEC, 7);   v(0, ANDI, 1, 10, C_IAND, 7);   v(0, ANDI, 1, 11, C_IWB, 7);
      v(0, XORI, 1, 0, C_FR, 8);   v(0, XORI, 1, 1, C_DEC, 8);   v(0, XORI, 1, 10, C_IXOR, 8);   v(0, XORI, 1, 11, C_IWB, 8);
      v(0, LUI, 1, 0, C_FR, 9);    v(0, LUI, 1, 1, C_DEC, 9);    v(0, LUI, 1, 10, C_ILUI, 9);    v(0, LUI, 1, 11, C_IWB, 9);
      v(0, SLTI, 1, 0, C_FR, 10);  v(0, SLTI, 1, 1, C_DEC, 10);  v(0, SLTI, 1, 10, C_ISLT, 10);  v(0, SLTI, 1, 11, C_IWB, 10);
      v(0, SLTIU, 1, 0, C_FR, 11); v(0, SLTIU, 1, 1, C_DEC, 11); v(0, SLTIU, 1, 10, C_ISLU, 11); v(0, SLTIU, 1, 11, C_IWB, 11);
      v(0, ADDIU, 1, 0, C_FR, 12); v(0, ADDIU, 1, 1, C_DEC, 12); v(0, ADDIU, 1, 10, C_IADU, 12); v(0, ADDIU, 1, 11, C_IWB, 12);
      // illegal opcode pulses exception once and retires nothing
      v(0, BAD, 1, 0, C_FR, 13); v(0, BAD, 1, 1, C_DECX, 13);
      // sw with one write stall
      v(0, SW, 1, 0, C_FR, 13);  v(0, SW, 1, 1, C_DEC, 13); v(0, SW, 1, 2, C_MADR, 13);
      v(0, SW, 0, 5, C_MWR, 13); v(0, SW, 1, 5, C_MWR, 13);
      // reset held three cycles in the middle of a stalled read
      v(0, LW, 1, 0, C_FR, 14);  v(0, LW, 1, 1, C_DEC, 14); v(0, LW, 1, 2, C_MADR, 14);
      v(0, LW, 0, 3, C_MRD, 14);
      v(1, LW, 1, 3, 20'h0, 14, C_EN); v(1, LW, 1, 0, 20'h0, 0, C_EN); v(1, LW, 1, 0, 20'h0, 0, C_EN);
      v(0, LW, 1, 0, C_FR, 0);   v(0, LW, 1, 1, C_DEC, 0);
      b0.opcode = R; b0.mem_ready = 1'b1; b1.opcode = J; b1.mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      foreach (tv[i]) begin
         @(negedge clk);
         reset = tv[i].rst; b0.opcode = tv[i].op; b0.mem_ready = tv[i].rdy;
         #1;
         chk($sformatf("state[%0d]", i), 32'(b0.state), 32'(tv[i].st));
         chk($sformatf("ctl[%0d]", i), 32'(ctl & tv[i].msk), 32'(tv[i].ctl & tv[i].msk));
         chk($sformatf("retired[%0d]", i), b0.retired, 32'(tv[i].ret));
      end
      // 4-bit counter wrap with MemReady ignored (held low)
      @(negedge clk); reset2 = 1'b0;
      @(negedge clk); #1;
      chk("wrap_decode_state", 32'(b1.state), 32'd1);
      repeat (47) @(negedge clk);
      #1;
      chk("wrap_16_retired", 32'(b1.retired), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      chk("wrap_17_retired", 32'(b1.retired), 32'd1);
      chk("wrap_17_state", 32'(b1.state), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
Moore-style control FSM for the multi-cycle MIPS datapath. It shares one memory port, one ALU and the IR/A/B/ALUOut/MDR registers across the cycles of each instruction. It sequences fetch, decode, execute, memory and writeback per opcode, stalls on a memory-ready handshake, flags illegal opcodes, and counts retired instructions.

Parameters:
USE_MEMREADY, 1, 1 = honour MemReady; 0 = treat MemReady as constant 1
CNT_WIDTH, 32, width of the Retired counter

Ports:
CLK  in  1  clock, all state changes on rising edge
Reset  in  1  synchronous, active-high
Opcode  in  6  IR[31:26], stable from end of FETCH until next FETCH
MemReady  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU Zero
IorD  out  1  0 = PC addresses memory, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
MemToReg  out  1  1 = MDR to register file
RegDst  out  1  1 = rd, 0 = rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = imm, 11 = imm<<2
PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
ALUOp  out  4  0000 ADD, 0001 SUB, 0010 FUNCT, 0011 OR, 0100 AND, 0101 XOR, 0110 LUI, 0111 SLT, 1000 SLTU
SignExtend  out  1  1 = sign-extend imm, 0 = zero-extend
Exception  out  1  one-cycle pulse on illegal opcode
State  out  4  current state code, for debug
Retired  out  CNT_WIDTH  retired instruction count, wraps

Behaviour:
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, RWB 7, BRANCH 8, JUMP 9, EXECI 10, IWB 11.
- Reset: State <= FETCH and Retired <= 0. While Reset = 1, force every enable output to 0 (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, Exception). Reset in any state aborts the instruction; no partial writes occur after the reset cycle.
- Unlisted outputs are 0 in every state. ALUOp defaults to ADD.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, PCSource = 00. IRWrite = PCWrite = MemReady. Hold FETCH while MemReady = 0; go to DECODE on MemReady = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, SignExtend = 1, ALUOp = ADD (branch target). Next state by Opcode:
  - 000000 → EXECR
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001101, 001000, 001001, 001100, 001111, 001010, 001011, 001110 → EXECI
  - any other opcode → Exception = 1 this cycle, next state FETCH, Retired unchanged.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, SignExtend = 1, ALUOp = ADD. lw → MEMRD; sw → MEMWR.
- MEMRD: MemRead = 1, IorD = 1. Hold until MemReady, then → MEMWB.
- MEMWB: RegWrite = 1, MemToReg = 1, RegDst = 0. → FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Hold until MemReady, then → FETCH.
- EXECR: ALUSrcA = 1, ALUSrcB = 00, ALUOp = FUNCT. → RWB.
- RWB: RegWrite = 1, RegDst = 1, MemToReg = 0. → FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = SUB, PCWriteCond = 1, PCSource = 01. → FETCH.
- JUMP: PCWrite = 1, PCSource = 10. → FETCH.
- EXECI: ALUSrcA = 1, ALUSrcB = 10. → IWB.
  - addi/addiu: ALUOp ADD, SignExtend 1
  - slti: SLT, SignExtend 1
  - sltiu: SLTU, SignExtend 1
  - ori: OR, SignExtend 0
  - andi: AND, SignExtend 0
  - xori: XOR, SignExtend 0
  - lui: LUI, SignExtend 0
- IWB: RegWrite = 1, RegDst = 0, MemToReg = 0. → FETCH.
- Retired increments by 1 on the cycle leaving MEMWB, MEMWR (MemReady = 1), RWB, BRANCH, JUMP or IWB. It wraps from all-ones to 0.
- Latency with MemReady held at 1:
  - beq, j: 3 cycles
  - R-type, sw, I-type ALU: 4 cycles
  - lw: 5 cycles
  - each MemReady = 0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- USE_MEMREADY = 0: ignore MemReady; memory states last exactly one cycle.
- No unreachable-state lockup: State codes 12–15 → FETCH next cycle with all enables 0.

Test Plan:
- Reset held 3 cycles mid-MEMRD, then released → State = 0, all enables 0 during reset, Retired = 0, fetch restarts with MemRead = 1.
- Opcodes R-type, lw, sw, beq, j, ori with MemReady = 1 → State sequences 0-1-6-7, 0-1-2-3-4, 0-1-2-5, 0-1-8, 0-1-9, 0-1-10-11; Retired = 6; outputs per state exactly as specified.
- lw with MemReady = 0 for 2 cycles in FETCH and 3 in MEMRD → 10 total cycles; IRWrite/PCWrite high only in the ready cycle; MemRead held throughout the waits.
- EXECI for andi, xori, lui, slti, sltiu, addiu → ALUOp 0100, 0101, 0110, 0111, 1000, 0000 and SignExtend 0, 0, 0, 1, 1, 1.
- Opcode 111111 → Exception = 1 for exactly one cycle in DECODE, next State = 0, Retired unchanged, no RegWrite or MemWrite.
- CNT_WIDTH = 4, 17 j instructions → Retired wraps to 1.
